// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the add/subtract pipeline.
//   OVF_WRAP / OVF_ZERO / OVF_SAT / OVF_RSVD : encodings of the 2-bit ovf_mode
//   input. OVF_RSVD falls back to wrap behaviour.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [1:0] OVF_WRAP = 2'b00;
  localparam logic [1:0] OVF_ZERO = 2'b01;
  localparam logic [1:0] OVF_SAT  = 2'b10;
  localparam logic [1:0] OVF_RSVD = 2'b11;

endpackage : alu_pkg

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// Combinational CW-bit adder slice used by one pipeline stage.
// Ports:
//   i_a, i_b  : chunk operands (i_b already inverted by the caller for subtract)
//   i_cin     : carry into the chunk LSB
//   o_sum     : chunk sum
//   o_cout    : carry out of the chunk MSB
//   o_cmsb    : carry into the chunk MSB (used for signed overflow on the top chunk)
// -----------------------------------------------------------------------------
module addsub_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_cin,
  output logic [CW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_cmsb
);

  logic [CW:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CW{1'b0}}, i_cin};
  assign o_sum  = w_full[CW-1:0];
  assign o_cout = w_full[CW];
  // The MSB sum bit is a ^ b ^ carry_in, so the carry into the MSB falls out
  // of the same XOR without a second adder.
  assign o_cmsb = o_sum[CW-1] ^ i_a[CW-1] ^ i_b[CW-1];

endmodule : addsub_chunk

// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
// Pipelined two's-complement adder/subtractor. Operands are split into STAGES
// chunks (LSB first); each stage adds one chunk and registers its carry. The
// final stage applies the overflow policy and drives registered outputs.
// Latency is STAGES cycles; the whole pipe stalls when the output is held.
//
// Parameters: WIDTH (2..64), STAGES (WIDTH must be a multiple of STAGES)
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (in_ready = out_ready | ~out_valid)
//   a, b, sub, ovf_mode  : operands, 0=add 1=subtract, overflow policy
//   out_valid / out_ready: output handshake
//   sum                  : result after policy
//   carry, overflow      : raw carry-out of MSB, raw signed overflow
//   zero                 : sum (after policy) is zero
// Configuration macro:
//   ADDSUB_PIPE_SAT_EN   : compiles in the saturate policy (ovf_mode 10);
//                          otherwise mode 10 behaves as wrap.
// -----------------------------------------------------------------------------
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [1:0]       ovf_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;
  // Inter-stage slots; kept at least one deep so a single-stage build elaborates.
  localparam int NMID = (STAGES > 1) ? STAGES - 1 : 1;

  // Inter-stage registers: slot k holds the beat after stage k has added its chunk.
  logic [NMID-1:0]  r_vld;
  logic [WIDTH-1:0] r_a   [NMID];
  logic [WIDTH-1:0] r_b   [NMID];
  logic [WIDTH-1:0] r_res [NMID];
  logic [NMID-1:0]  r_cy;
  logic [NMID-1:0]  r_sub;
  logic [1:0]       r_mode[NMID];

  // Output registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;

  // Per-stage inputs and chunk results
  logic [WIDTH-1:0]           w_a      [STAGES];
  logic [WIDTH-1:0]           w_b      [STAGES];
  logic [WIDTH-1:0]           w_res    [STAGES];
  logic [WIDTH-1:0]           w_res_nxt[STAGES];
  logic [1:0]                 w_mode   [STAGES];
  logic [STAGES-1:0]          w_vld;
  logic [STAGES-1:0]          w_sub;
  logic [STAGES-1:0]          w_cin;
  logic [STAGES-1:0][CW-1:0]  w_csum;
  logic [STAGES-1:0]          w_cout;
  logic [STAGES-1:0]          w_cmsb;

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_pol;
  logic             w_ovf;
  logic             w_unused;

  // The pipe moves as one unit; a held output freezes every stage behind it.
  assign in_ready = out_ready | ~r_out_valid;

  // Stage 0 is fed from the ports, later stages from the previous slot.
  // Subtract enters stage 0 as carry-in 1 (A + ~B + 1).
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    w_a[0]    = a;
    w_b[0]    = b;
    w_res[0]  = '0;
    w_cin[0]  = sub;
    w_sub[0]  = sub;
    w_mode[0] = ovf_mode;
    w_vld[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_a[k]    = r_a[k-1];
      w_b[k]    = r_b[k-1];
      w_res[k]  = r_res[k-1];
      w_cin[k]  = r_cy[k-1];
      w_sub[k]  = r_sub[k-1];
      w_mode[k] = r_mode[k-1];
      w_vld[k]  = r_vld[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW-1:0] w_b_chunk;
    assign w_b_chunk = w_b[k][k*CW +: CW] ^ {CW{w_sub[k]}};

    addsub_chunk #(.CW(CW)) u_chunk (
      .i_a    (w_a[k][k*CW +: CW]),
      .i_b    (w_b_chunk),
      .i_cin  (w_cin[k]),
      .o_sum  (w_csum[k]),
      .o_cout (w_cout[k]),
      .o_cmsb (w_cmsb[k])
    );
  end

  // Merge each stage's chunk into the partial result it carries forward.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_res_nxt[k]              = w_res[k];
      w_res_nxt[k][k*CW +: CW]  = w_csum[k];
    end
  end

  // Bits a stage no longer needs (consumed low operand chunks, stale upper
  // result bits, inner-chunk MSB carries) are collected here and left unused.
  always_comb begin
    w_unused = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      w_unused = w_unused ^ (^w_a[k]) ^ (^w_b[k]) ^ (^w_res[k]) ^ w_cmsb[k];
    end
  end

  // NOTE: only valid bits are reset; slot data is don't-care while its valid
  // bit is 0, so the wide operand/result registers stay reset-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (in_ready) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        r_vld[k] <= w_vld[k];
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (in_ready) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        r_a[k]    <= w_a[k];
        r_b[k]    <= w_b[k];
        r_res[k]  <= w_res_nxt[k];
        r_cy[k]   <= w_cout[k];
        r_sub[k]  <= w_sub[k];
        r_mode[k] <= w_mode[k];
      end
    end
  end

  // Final stage: raw result and signed overflow from the top chunk.
  assign w_raw = w_res_nxt[LAST];
  assign w_ovf = w_cout[LAST] ^ w_cmsb[LAST];

  // Policy only alters sum; carry and overflow always report raw arithmetic.
  always_comb begin
    w_pol = w_raw;
    if (w_ovf) begin
      case (w_mode[LAST])
        OVF_ZERO: w_pol = '0;
`ifdef ADDSUB_PIPE_SAT_EN
        // Overflow direction follows A's sign for both add and subtract.
        OVF_SAT:  w_pol = w_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        default:  w_pol = w_raw;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (in_ready) begin
      r_out_valid <= w_vld[LAST];
      r_sum       <= w_pol;
      r_carry     <= w_cout[LAST];
      r_ovf       <= w_ovf;
      r_zero      <= (w_pol == '0);
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule : addsub_pipe

// File: tb/tb_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_addsub_pipe
// Directed bench for addsub_pipe: an 8-bit/2-stage instance for the directed
// vectors and handshake scenarios, and a 32-bit/4-stage instance for a
// scoreboarded random stream. Honours ADDSUB_PIPE_SAT_EN for expected values.
// -----------------------------------------------------------------------------
module tb_addsub_pipe;
  import alu_pkg::*;

`ifdef ADDSUB_PIPE_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 8-bit / 2-stage instance
  logic       d8_in_valid = 1'b0, d8_in_ready, d8_sub = 1'b0;
  logic [7:0] d8_a = '0, d8_b = '0, d8_sum;
  logic [1:0] d8_mode = OVF_WRAP;
  logic       d8_out_valid, d8_out_ready = 1'b1, d8_carry, d8_ovf, d8_zero;

  addsub_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .a(d8_a), .b(d8_b), .sub(d8_sub), .ovf_mode(d8_mode),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .sum(d8_sum), .carry(d8_carry), .overflow(d8_ovf), .zero(d8_zero)
  );

  // 32-bit / 4-stage instance
  logic        d32_in_valid = 1'b0, d32_in_ready, d32_sub = 1'b0;
  logic [31:0] d32_a = '0, d32_b = '0, d32_sum;
  logic [1:0]  d32_mode = OVF_WRAP;
  logic        d32_out_valid, d32_out_ready = 1'b1, d32_carry, d32_ovf, d32_zero;

  addsub_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d32_in_valid), .in_ready(d32_in_ready),
    .a(d32_a), .b(d32_b), .sub(d32_sub), .ovf_mode(d32_mode),
    .out_valid(d32_out_valid), .out_ready(d32_out_ready),
    .sum(d32_sum), .carry(d32_carry), .overflow(d32_ovf), .zero(d32_zero)
  );

  // Reference: signed overflow from operand/result signs, policy applied after.
  function automatic logic [34:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic [1:0] m);
    logic [32:0] full;
    logic [31:0] raw, res;
    logic        ovf;
    full = s ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
    raw  = full[31:0];
    ovf  = s ? ((a[31] != b[31]) && (raw[31] != a[31]))
             : ((a[31] == b[31]) && (raw[31] != a[31]));
    res  = raw;
    if (ovf && m == OVF_ZERO) res = '0;
    else if (ovf && m == OVF_SAT && SAT_ON) res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {res, full[32], ovf, (res == 32'd0)};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One beat through the 8-bit pipe with out_ready high; returns the result
  // and the number of rising edges from acceptance to out_valid.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [1:0] m, output logic [7:0] rs, output logic rc,
                      output logic ro, output logic rz, output int lat);
    d8_out_ready = 1'b1;
    @(negedge clk);
    d8_a = a; d8_b = b; d8_sub = s; d8_mode = m; d8_in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    d8_in_valid = 1'b0;
    while (!d8_out_valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    rs = d8_sum; rc = d8_carry; ro = d8_ovf; rz = d8_zero;
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", d8_out_valid); end
    n_checks++; if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", d8_in_ready); end
    n_checks++; if ({d8_sum, d8_carry, d8_ovf, d8_zero} !== 11'd0) begin n_fail++; $display("FAIL reset_outputs: got %h/%b%b%b want 00/000", d8_sum, d8_carry, d8_ovf, d8_zero); end
    n_checks++; if (d32_out_valid !== 1'b0 || d32_sum !== 32'd0) begin n_fail++; $display("FAIL reset_wide: got v=%b sum=%h want v=0 sum=0", d32_out_valid, d32_sum); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", d8_in_ready); end
  endtask

  task automatic test_policies;
    logic [7:0] s; logic c, o, z; int lat;
    run8(8'h64, 8'h32, 1'b0, OVF_WRAP, s, c, o, z, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL latency8: got %0d want 2", lat); end
    n_checks++; if ({s, c, o, z} !== {8'h96, 3'b010}) begin n_fail++; $display("FAIL wrap_add: got %h c%b o%b z%b want 96 c0 o1 z0", s, c, o, z); end
    run8(8'h64, 8'h32, 1'b0, OVF_ZERO, s, c, o, z, lat);
    n_checks++; if ({s, c, o, z} !== {8'h00, 3'b011}) begin n_fail++; $display("FAIL zero_mode: got %h c%b o%b z%b want 00 c0 o1 z1", s, c, o, z); end
    run8(8'h64, 8'h32, 1'b0, OVF_SAT, s, c, o, z, lat);
    n_checks++; if ({s, o} !== {(SAT_ON ? 8'h7F : 8'h96), 1'b1}) begin n_fail++; $display("FAIL sat_pos: got %h o%b want %h o1", s, o, SAT_ON ? 8'h7F : 8'h96); end
    run8(8'h64, 8'h32, 1'b0, OVF_RSVD, s, c, o, z, lat);
    n_checks++; if ({s, o} !== {8'h96, 1'b1}) begin n_fail++; $display("FAIL rsvd_mode: got %h o%b want 96 o1", s, o); end
  endtask

  task automatic test_subtract;
    logic [7:0] s; logic c, o, z; int lat;
    run8(8'h10, 8'h20, 1'b1, OVF_WRAP, s, c, o, z, lat);
    n_checks++; if ({s, c, o, z} !== {8'hF0, 3'b000}) begin n_fail++; $display("FAIL sub_borrow: got %h c%b o%b z%b want F0 c0 o0 z0", s, c, o, z); end
    run8(8'h80, 8'h01, 1'b1, OVF_SAT, s, c, o, z, lat);
    n_checks++; if ({s, c, o} !== {(SAT_ON ? 8'h80 : 8'h7F), 2'b11}) begin n_fail++; $display("FAIL sat_neg: got %h c%b o%b want %h c1 o1", s, c, o, SAT_ON ? 8'h80 : 8'h7F); end
    run8(8'h05, 8'h05, 1'b1, OVF_ZERO, s, c, o, z, lat);
    n_checks++; if ({s, c, o, z} !== {8'h00, 3'b101}) begin n_fail++; $display("FAIL sub_equal: got %h c%b o%b z%b want 00 c1 o0 z1", s, c, o, z); end
  endtask

  task automatic test_chunk_carry;
    logic [7:0] s; logic c, o, z; int lat;
    // Carry crosses the chunk boundary; no overflow so zero policy must not act.
    run8(8'h0F, 8'h01, 1'b0, OVF_ZERO, s, c, o, z, lat);
    n_checks++; if ({s, c, o, z} !== {8'h10, 3'b000}) begin n_fail++; $display("FAIL chunk_carry: got %h c%b o%b z%b want 10 c0 o0 z0", s, c, o, z); end
    run8(8'hFF, 8'h01, 1'b0, OVF_WRAP, s, c, o, z, lat);
    n_checks++; if ({s, c, o, z} !== {8'h00, 3'b101}) begin n_fail++; $display("FAIL carry_out: got %h c%b o%b z%b want 00 c1 o0 z1", s, c, o, z); end
  endtask

  task automatic test_throughput;
    logic [7:0] ea[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int got = 0, first = -1, last = -1;
    bit all_ready = 1'b1;
    d8_out_ready = 1'b1; d8_sub = 1'b0; d8_mode = OVF_WRAP; d8_b = 8'h00;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      if (d8_out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        n_checks++; if (d8_sum !== ea[got]) begin n_fail++; $display("FAIL stream_%0d: got %h want %h", got, d8_sum, ea[got]); end
        got++;
      end
      if (cyc < 4) begin
        d8_a = ea[cyc]; d8_in_valid = 1'b1;
        if (d8_in_ready !== 1'b1) all_ready = 1'b0;
      end else d8_in_valid = 1'b0;
    end
    d8_in_valid = 1'b0;
    n_checks++; if (first !== 2 || last !== 5) begin n_fail++; $display("FAIL stream_timing: got first=%0d last=%0d want 2/5", first, last); end
    n_checks++; if (all_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready: got in_ready low want always high"); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ta[4] = '{8'h01, 8'h10, 8'h7F, 8'h11};
    logic [7:0] tbv[4] = '{8'h02, 8'h20, 8'h01, 8'h22};
    logic       ts[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ex[4] = '{8'h03, 8'h30, 8'h7E, 8'h33};
    int sent = 0, got = 0, stall = 0, cyc = 0;
    bit seen = 1'b0;
    logic [7:0] held = '0;
    d8_mode = OVF_WRAP;
    while (got < 4 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (!seen && d8_out_valid) begin seen = 1'b1; stall = 3; held = d8_sum; end
      d8_out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        n_checks++; if (d8_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", d8_in_ready); end
        if (stall < 3) begin
          n_checks++; if (d8_out_valid !== 1'b1 || d8_sum !== held) begin n_fail++; $display("FAIL stall_hold: got v=%b sum=%h want v=1 sum=%h", d8_out_valid, d8_sum, held); end
        end
        stall--;
      end
      if (d8_out_valid && d8_out_ready) begin
        n_checks++; if (d8_sum !== ex[got]) begin n_fail++; $display("FAIL b2b_%0d: got %h want %h", got, d8_sum, ex[got]); end
        got++;
      end
      if (sent < 4) begin
        d8_a = ta[sent]; d8_b = tbv[sent]; d8_sub = ts[sent]; d8_in_valid = 1'b1;
        if (d8_in_ready) sent++;
      end else d8_in_valid = 1'b0;
    end
    d8_in_valid = 1'b0; d8_out_ready = 1'b1;
    n_checks++; if (got !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", got); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_extra: got out_valid=%b want 0", d8_out_valid); end
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] s; logic c, o, z; int lat;
    d8_out_ready = 1'b0; d8_sub = 1'b0; d8_mode = OVF_WRAP;
    @(negedge clk); d8_a = 8'h01; d8_b = 8'h01; d8_in_valid = 1'b1;
    @(negedge clk); d8_a = 8'h02; d8_b = 8'h02;
    @(negedge clk); d8_in_valid = 1'b0;
    n_checks++; if (d8_out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", d8_out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (d8_out_valid !== 1'b0 || d8_sum !== 8'h00 || d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset: got v=%b sum=%h rdy=%b want 0/00/1", d8_out_valid, d8_sum, d8_in_ready); end
    @(negedge clk); rst_n = 1'b1; d8_out_ready = 1'b1;
    #1;
    n_checks++; if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_release_ready: got %b want 1", d8_in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL ghost_beat_%0d: got out_valid=%b want 0", i, d8_out_valid); end
    end
    run8(8'h21, 8'h13, 1'b0, OVF_WRAP, s, c, o, z, lat);
    n_checks++; if (s !== 8'h34 || lat !== 2) begin n_fail++; $display("FAIL after_reset_beat: got %h lat %0d want 34 lat 2", s, lat); end
  endtask

  task automatic test_wide_random;
    logic [34:0] q[$];
    logic [34:0] ex;
    logic [31:0] na = '0, nb = '0;
    logic        ns = 1'b0;
    logic [1:0]  nm = '0;
    bit have = 1'b0;
    int sent = 0, cyc = 0, lat;

    // Single beat, no stall: latency check.
    d32_out_ready = 1'b1;
    @(negedge clk);
    d32_a = 32'h1234_5678; d32_b = 32'h1111_1111; d32_sub = 1'b0; d32_mode = OVF_WRAP; d32_in_valid = 1'b1;
    @(posedge clk); lat = 1;
    @(negedge clk); d32_in_valid = 1'b0;
    while (!d32_out_valid && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    n_checks++; if (lat !== 4 || d32_sum !== 32'h2345_6789) begin n_fail++; $display("FAIL wide_latency: got lat %0d sum %h want 4 23456789", lat, d32_sum); end

    while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
      @(negedge clk); cyc++;
      d32_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (d32_out_valid && d32_out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL wide_unexpected: got sum %h want no beat", d32_sum);
        end else begin
          ex = q.pop_front();
          if ({d32_sum, d32_carry, d32_ovf, d32_zero} !== ex) begin
            n_fail++;
            $display("FAIL wide_beat: got %h c%b o%b z%b want %h c%b o%b z%b",
                     d32_sum, d32_carry, d32_ovf, d32_zero, ex[34:3], ex[2], ex[1], ex[0]);
          end
        end
      end
      if (sent < 1000) begin
        if (!have) begin
          na = pick32(); nb = pick32(); ns = 1'($urandom_range(0, 1)); nm = 2'($urandom_range(0, 3));
          have = 1'b1;
        end
        d32_a = na; d32_b = nb; d32_sub = ns; d32_mode = nm; d32_in_valid = 1'b1;
        if (d32_in_ready) begin
          q.push_back(model32(na, nb, ns, nm));
          sent++; have = 1'b0;
        end
      end else d32_in_valid = 1'b0;
    end
    d32_in_valid = 1'b0;
    n_checks++; if (sent !== 1000 || q.size() !== 0) begin n_fail++; $display("FAIL wide_drain: got sent %0d pending %0d want 1000/0", sent, q.size()); end
  endtask

  initial begin
    test_reset();
    test_policies();
    test_subtract();
    test_chunk_carry();
    test_throughput();
    test_back_to_back();
    test_mid_reset();
    test_wide_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_addsub_pipe

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand/result width in bits; legal range is 2 to 64.
REQ-002 Parameter STAGES, default 2, sets the pipeline depth; WIDTH SHALL be a multiple of STAGES.
REQ-003 Port clk, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1 bit: the operand beat is valid.
REQ-006 Port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 Port a, input, WIDTH bits: operand A, two's complement.
REQ-008 Port b, input, WIDTH bits: operand B, two's complement.
REQ-009 Port sub, input, 1 bit: 0 computes A+B; 1 computes A-B.
REQ-010 Port ovf_mode, input, 2 bits: overflow policy, where 00 = wrap, 01 = zero, 10 = saturate, and 11 = reserved (behaves as wrap).
REQ-011 Port out_valid, output, 1 bit: the result beat is valid.
REQ-012 Port out_ready, input, 1 bit: the downstream sink accepts the result.
REQ-013 Port sum, output, WIDTH bits: the result after the overflow policy is applied.
REQ-014 Port carry, output, 1 bit: raw carry-out of the MSB; for subtract, 1 means no borrow.
REQ-015 Port overflow, output, 1 bit: signed overflow, defined as carry into the MSB XOR carry out of the MSB.
REQ-016 Port zero, output, 1 bit: sum equals 0 after the policy is applied.

Function
REQ-017 The block SHALL split the operands into STAGES chunks of WIDTH/STAGES bits, LSB chunk first; each stage SHALL add one chunk and register its carry for the next stage.
REQ-018 Subtract SHALL be performed as A + ~B with carry-in 1; add SHALL use carry-in 0.
REQ-019 The operand upper chunks, sub and ovf_mode SHALL travel with the beat through the pipeline registers.
REQ-020 Latency SHALL be exactly STAGES cycles from an accepted input to out_valid when there is no stall.
REQ-021 A beat is accepted when in_valid and in_ready are both high; a result is consumed when out_valid and out_ready are both high.
REQ-022 in_ready SHALL equal out_ready OR NOT out_valid; the pipeline advances as a whole only when in_ready is high.
REQ-023 While the pipeline is stalled, all stage registers and outputs SHALL hold their values, and sum and the flags SHALL stay stable while out_valid is high.
REQ-024 Sustained throughput SHALL be one beat per cycle while out_ready is held high.
REQ-025 Overflow policy SHALL apply only when overflow is 1:
  - wrap: sum is the raw result.
  - zero: sum is all zeros.
  - saturate: sum is the maximum positive value if A's MSB is 0, otherwise the minimum negative value.
REQ-026 The carry and overflow flags SHALL always report the raw arithmetic, independent of the policy.
REQ-027 A pipeline slot holding no valid beat SHALL carry a valid bit of 0; its data contents are don't-care.

Reset
REQ-028 On rst_n low, all stage valid bits and out_valid SHALL clear immediately; sum, carry, overflow and zero SHALL reset to 0.
REQ-029 A reset asserted mid-operation SHALL discard all in-flight beats; no partial result SHALL emerge after release.
REQ-030 in_ready SHALL read 1 during reset and on the first cycle after reset release.

Configuration
REQ-031 Macro ADDSUB_PIPE_SAT_EN, when defined, SHALL compile in the saturate policy (ovf_mode 10).
REQ-032 When ADDSUB_PIPE_SAT_EN is undefined, the saturation logic SHALL be absent, and ovf_mode 10 SHALL behave as wrap.

Structure
REQ-033 The ovf_mode encodings (OVF_WRAP, OVF_ZERO, OVF_SAT, OVF_RSVD) SHALL be defined as constants in the shared package alu_pkg.
REQ-034 One sub-module, addsub_chunk, SHALL implement the combinational chunk adder (chunk A, chunk B, cin in; chunk sum, carry out, carry into MSB out); it SHALL be instantiated once per stage.

Verification
The bench runs with WIDTH=8, STAGES=2 unless stated otherwise.
REQ-035 a=0x64, b=0x32, sub=0, mode wrap -> after 2 cycles sum=0x96, overflow=1, carry=0.
REQ-036 The same operands with mode zero -> sum=0x00, zero=1, overflow=1; with mode saturate and the macro defined -> sum=0x7F; with mode saturate and the macro undefined -> sum=0x96.
REQ-037 a=0x10, b=0x20, sub=1 -> sum=0xF0, carry=0, overflow=0; then a=0x80, b=0x01, sub=1, mode saturate -> sum=0x80, overflow=1.
REQ-038 Drive 4 back-to-back beats and hold out_ready low for 3 cycles after the first result -> in_ready falls, out_valid and sum hold, all 4 results arrive in order with none lost or duplicated.
REQ-039 Assert rst_n low while 2 beats are in flight -> out_valid=0 immediately and stays 0 after release until a new beat is accepted.
REQ-040 With WIDTH=32, STAGES=4, drive 1000 random beats in all modes -> every result matches the reference model, and latency is 4 cycles when there is no stall.
